// File: rtl/stamp_dispatcher_if.sv
// rtl/stamp_dispatcher_if.sv - issue/completion handshake bundle between the dispatcher and its three stage units
interface stamp_dispatcher_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [87:0] ex_cmd;
  logic        ex_done;
  logic [4:0]  ex_take;

  logic        mem_valid;
  logic        mem_ready;
  logic [87:0] mem_cmd;
  logic        mem_done;

  logic        wb_valid;
  logic        wb_ready;
  logic [87:0] wb_cmd;
  logic        wb_done;

  modport master (
    output ex_valid, ex_cmd, mem_valid, mem_cmd, wb_valid, wb_cmd,
    input  ex_ready, ex_done, ex_take, mem_ready, mem_done, wb_ready, wb_done
  );

  modport slave (
    input  ex_valid, ex_cmd, mem_valid, mem_cmd, wb_valid, wb_cmd,
    output ex_ready, ex_done, ex_take, mem_ready, mem_done, wb_ready, wb_done
  );
endinterface

// File: rtl/stamp_dispatcher.sv
// rtl/stamp_dispatcher.sv - oldest-first issue and stamp write-back for the 8-slot conveyor
// Optional take write-back on the exec unit is enabled by DISPATCH_TAKE_EN.
module stamp_dispatcher (
  input  logic                clk,
  input  logic                rst,
  input  logic [23:0]         reg_start_flat,
  input  logic [703:0]        reg_out_flat,
  input  logic                conveyor_shift,
  stamp_dispatcher_if.master  unit,
  output logic [23:0]         stamp_flat,
  output logic [7:0]          stamp_in,
  output logic [39:0]         take_flat,
  output logic [7:0]          take_in,
  output logic [2:0]          unit_busy,
  output logic                dispatch_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, STAMP} state_t;

  // Unit index u: 2 = exec, 1 = mem, 0 = wb (matches stamp bit order)
  state_t      state [3];
  logic [2:0]  idx   [3];
  logic [87:0] cmd   [3];

  logic [2:0]  ready_v;
  logic [2:0]  done_v;
  logic [2:0]  sel_hit;
  logic [2:0]  sel_k [3];
  logic [7:0]  owned;

  assign ready_v = {unit.ex_ready, unit.mem_ready, unit.wb_ready};
  assign done_v  = {unit.ex_done,  unit.mem_done,  unit.wb_done};

  // Idle units claim slots in exec, mem, wb order so no two end up on the same slot
  always_comb begin
    owned = '0;
    for (int u = 0; u < 3; u++) begin
      sel_hit[u] = 1'b0;
      sel_k[u]   = '0;
      if (state[u] != IDLE) owned[idx[u]] = 1'b1;
    end
    for (int u = 2; u >= 0; u--) begin
      if (state[u] == IDLE) begin
        for (int k = 0; k < 8; k++) begin
          if (reg_start_flat[3*k+u] && !owned[k]) begin
            sel_hit[u] = 1'b1;
            sel_k[u]   = 3'(k);
          end
        end
        if (sel_hit[u]) owned[sel_k[u]] = 1'b1;
      end
    end
  end

`ifdef DISPATCH_TAKE_EN
  logic [4:0] take_q;
`else
  logic unused_take;
  assign unused_take = ^unit.ex_take;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int u = 0; u < 3; u++) begin
        state[u] <= IDLE;
        idx[u]   <= '0;
        cmd[u]   <= '0;
      end
      dispatch_err <= 1'b0;
`ifdef DISPATCH_TAKE_EN
      take_q <= '0;
`endif
    end else begin
      for (int u = 0; u < 3; u++) begin
        if (done_v[u] && state[u] != BUSY) dispatch_err <= 1'b1;
        if (state[u] != IDLE && conveyor_shift) begin
          if (idx[u] == 3'd7) dispatch_err <= 1'b1;
          else                idx[u] <= idx[u] + 3'd1;
        end
        case (state[u])
          IDLE: begin
            if (sel_hit[u]) begin
              cmd[u] <= reg_out_flat[88*sel_k[u] +: 88];
              if (conveyor_shift && sel_k[u] == 3'd7) begin
                dispatch_err <= 1'b1;
                idx[u]       <= 3'd7;
              end else begin
                idx[u] <= sel_k[u] + 3'(conveyor_shift);
              end
              state[u] <= ISSUE;
            end
          end
          ISSUE:   if (ready_v[u]) state[u] <= BUSY;
          BUSY:    if (done_v[u]) state[u] <= STAMP;
          STAMP:   if (!conveyor_shift) state[u] <= IDLE;
          default: state[u] <= IDLE;
        endcase
      end
`ifdef DISPATCH_TAKE_EN
      if (state[2] == BUSY && unit.ex_done) take_q <= unit.ex_take;
`endif
    end
  end

  assign unit.ex_valid  = (state[2] == ISSUE);
  assign unit.mem_valid = (state[1] == ISSUE);
  assign unit.wb_valid  = (state[0] == ISSUE);
  assign unit.ex_cmd    = cmd[2];
  assign unit.mem_cmd   = cmd[1];
  assign unit.wb_cmd    = cmd[0];

  always_comb begin
    unit_busy = '0;
    for (int u = 0; u < 3; u++) unit_busy[u] = (state[u] != IDLE);
  end

  // Stamp write merges the unit's done bit into the slot's current stamp; held off on shift cycles
  always_comb begin
    stamp_flat = '0;
    stamp_in   = '0;
    for (int u = 0; u < 3; u++) begin
      if (state[u] == STAMP && !conveyor_shift) begin
        stamp_in[idx[u]]          = 1'b1;
        stamp_flat[3*idx[u] +: 3] = reg_out_flat[88*idx[u] +: 3] | 3'(1 << u);
      end
    end
  end

`ifdef DISPATCH_TAKE_EN
  always_comb begin
    take_flat = '0;
    take_in   = '0;
    if (state[2] == STAMP && !conveyor_shift) begin
      take_in[idx[2]]          = 1'b1;
      take_flat[5*idx[2] +: 5] = take_q;
    end
  end
`else
  assign take_flat = '0;
  assign take_in   = '0;
`endif

endmodule

// File: tb/tb_stamp_dispatcher.sv
// tb/tb_stamp_dispatcher.sv - directed table-driven bench for stamp_dispatcher
module tb_stamp_dispatcher;
  logic         clk;
  logic         rst;
  logic [23:0]  reg_start_flat;
  logic [703:0] reg_out_flat;
  logic         shift;
  logic [23:0]  stamp_flat;
  logic [7:0]   stamp_in;
  logic [39:0]  take_flat;
  logic [7:0]   take_in;
  logic [2:0]   unit_busy;
  logic         dispatch_err;

  logic [87:0]  slots [8];
  logic [2:0]   start [8];

  int errors = 0;
  int checks = 0;

  stamp_dispatcher_if bus();

  stamp_dispatcher dut (
    .clk            (clk),
    .rst            (rst),
    .reg_start_flat (reg_start_flat),
    .reg_out_flat   (reg_out_flat),
    .conveyor_shift (shift),
    .unit           (bus),
    .stamp_flat     (stamp_flat),
    .stamp_in       (stamp_in),
    .take_flat      (take_flat),
    .take_in        (take_in),
    .unit_busy      (unit_busy),
    .dispatch_err   (dispatch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      reg_out_flat[88*k +: 88] = slots[k];
      reg_start_flat[3*k +: 3] = start[k];
    end
  end

  typedef struct {
    int          unit;
    int          slot;
    logic [2:0]  pre;
    logic [7:0]  exp_in;
    logic [23:0] exp_flat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic init_slots();
    for (int k = 0; k < 8; k++) begin
      slots[k] = {8'(8'hA0 + k), 40'h12_3456_789A, 37'(k * 7 + 1), 3'b000};
      start[k] = 3'b000;
    end
  endtask

  // Advance one clock; a shift seen at the edge moves the conveyor model by one slot
  task automatic cyc();
    logic sh;
    @(posedge clk);
    sh = shift;
    #1;
    if (sh) begin
      for (int k = 7; k > 0; k--) begin
        slots[k] = slots[k-1];
        start[k] = start[k-1];
      end
      slots[0] = '0;
      start[0] = 3'b000;
    end
    shift = 1'b0;
    bus.ex_ready = 1'b0; bus.mem_ready = 1'b0; bus.wb_ready = 1'b0;
    bus.ex_done  = 1'b0; bus.mem_done  = 1'b0; bus.wb_done  = 1'b0;
    bus.ex_take  = 5'd0;
  endtask

  task automatic set_ready(input int u);
    if (u == 2) bus.ex_ready = 1'b1;
    else if (u == 1) bus.mem_ready = 1'b1;
    else bus.wb_ready = 1'b1;
  endtask

  task automatic set_done(input int u);
    if (u == 2) bus.ex_done = 1'b1;
    else if (u == 1) bus.mem_done = 1'b1;
    else bus.wb_done = 1'b1;
  endtask

  function automatic logic valid_of(input int u);
    if (u == 2) return bus.ex_valid;
    if (u == 1) return bus.mem_valid;
    return bus.wb_valid;
  endfunction

  function automatic logic [87:0] cmd_of(input int u);
    if (u == 2) return bus.ex_cmd;
    if (u == 1) return bus.mem_cmd;
    return bus.wb_cmd;
  endfunction

  initial begin
    vecs[0] = '{2, 3, 3'b000, 8'h08, 24'h000800};
    vecs[1] = '{1, 6, 3'b100, 8'h40, 24'h180000};
    vecs[2] = '{0, 0, 3'b110, 8'h01, 24'h000007};
    vecs[3] = '{2, 7, 3'b011, 8'h80, 24'hE00000};
    vecs[4] = '{1, 1, 3'b001, 8'h02, 24'h000018};
    vecs[5] = '{0, 5, 3'b000, 8'h20, 24'h008000};

    rst = 1'b1;
    shift = 1'b0;
    bus.ex_ready = 1'b0; bus.mem_ready = 1'b0; bus.wb_ready = 1'b0;
    bus.ex_done  = 1'b0; bus.mem_done  = 1'b0; bus.wb_done  = 1'b0;
    bus.ex_take  = 5'd0;
    init_slots();

    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stamp_in", stamp_in, 8'h00);
    chk("rst_stamp_flat", stamp_flat, 24'h0);
    chk("rst_take_in", take_in, 8'h00);
    chk("rst_take_flat", take_flat, 40'h0);
    chk("rst_busy", unit_busy, 3'b000);
    chk("rst_err", dispatch_err, 1'b0);
    chk("rst_valid", {bus.ex_valid, bus.mem_valid, bus.wb_valid}, 3'b000);
    chk("rst_ex_cmd", bus.ex_cmd, 88'h0);

    for (int i = 0; i < 6; i++) begin
      init_slots();
      slots[vecs[i].slot][2:0] = vecs[i].pre;
      start[vecs[i].slot][vecs[i].unit] = 1'b1;
      @(negedge clk);
      cyc();
      set_ready(vecs[i].unit);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), valid_of(vecs[i].unit), 1'b1);
      chk($sformatf("v%0d_cmd", i), cmd_of(vecs[i].unit), slots[vecs[i].slot]);
      cyc();
      set_done(vecs[i].unit);
      @(negedge clk);
      cyc();
      @(negedge clk);
      chk($sformatf("v%0d_stamp_in", i), stamp_in, vecs[i].exp_in);
      chk($sformatf("v%0d_stamp_flat", i), stamp_flat, vecs[i].exp_flat);
      cyc();
      start[vecs[i].slot][vecs[i].unit] = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), unit_busy, 3'b000);
      chk($sformatf("v%0d_idle_stamp", i), stamp_in, 8'h00);
    end

    // Oldest first: mem sees slots 2 and 6, takes 6, then 2 once 6 is stamped
    init_slots();
    start[2][1] = 1'b1;
    start[6][1] = 1'b1;
    @(negedge clk);
    cyc();
    set_ready(1);
    @(negedge clk);
    chk("old_first_cmd", bus.mem_cmd, slots[6]);
    cyc();
    set_done(1);
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("old_first_stamp", stamp_in, 8'h40);
    cyc();
    start[6][1] = 1'b0;
    @(negedge clk);
    cyc();
    set_ready(1);
    @(negedge clk);
    chk("old_second_valid", bus.mem_valid, 1'b1);
    chk("old_second_cmd", bus.mem_cmd, slots[2]);
    cyc();
    set_done(1);
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("old_second_stamp", stamp_in, 8'h04);
    cyc();
    start[2][1] = 1'b0;
    @(negedge clk);

    // Two shifts while BUSY carry exec's slot 4 to slot 6
    init_slots();
    slots[4][2:0] = 3'b010;
    start[4][2] = 1'b1;
    @(negedge clk);
    cyc();
    set_ready(2);
    @(negedge clk);
    cyc();
    shift = 1'b1;
    @(negedge clk);
    cyc();
    shift = 1'b1;
    @(negedge clk);
    cyc();
    set_done(2);
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("shift2_stamp_in", stamp_in, 8'h40);
    chk("shift2_stamp_flat", stamp_flat, 24'h180000);
    cyc();
    start[6][2] = 1'b0;
    @(negedge clk);

    // One shift in BUSY plus one in the done+1 cycle: write delayed a cycle, lands on slot 6
    init_slots();
    slots[4][2:0] = 3'b001;
    start[4][2] = 1'b1;
    @(negedge clk);
    cyc();
    set_ready(2);
    @(negedge clk);
    cyc();
    shift = 1'b1;
    @(negedge clk);
    cyc();
    set_done(2);
    @(negedge clk);
    cyc();
    shift = 1'b1;
    @(negedge clk);
    chk("shift_hold_stamp_in", stamp_in, 8'h00);
    cyc();
    @(negedge clk);
    chk("shift_late_stamp_in", stamp_in, 8'h40);
    chk("shift_late_stamp_flat", stamp_flat, 24'h140000);
    cyc();
    start[6][2] = 1'b0;
    @(negedge clk);
    chk("shift_no_err", dispatch_err, 1'b0);

    // Concurrent: ex on slot 1, wb on slot 5 finish together
    init_slots();
    slots[1][2:0] = 3'b010;
    slots[5][2:0] = 3'b100;
    start[1][2] = 1'b1;
    start[5][0] = 1'b1;
    @(negedge clk);
    cyc();
    set_ready(2);
    set_ready(0);
    @(negedge clk);
    chk("conc_busy", unit_busy, 3'b101);
    cyc();
    set_done(2);
    set_done(0);
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("conc_stamp_in", stamp_in, 8'h22);
    chk("conc_stamp_flat", stamp_flat, 24'h028030);
    cyc();
    start[1][2] = 1'b0;
    start[5][0] = 1'b0;
    @(negedge clk);
    chk("err_before", dispatch_err, 1'b0);
    set_done(1);
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("err_set", dispatch_err, 1'b1);
    cyc();
    cyc();
    @(negedge clk);
    chk("err_sticky", dispatch_err, 1'b1);

    // Take write-back on exec for slot 2
    init_slots();
    start[2][2] = 1'b1;
    @(negedge clk);
    cyc();
    set_ready(2);
    @(negedge clk);
    cyc();
    set_done(2);
    bus.ex_take = 5'd17;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("take_stamp_in", stamp_in, 8'h04);
`ifdef DISPATCH_TAKE_EN
    chk("take_in", take_in, 8'h04);
    chk("take_flat", take_flat, 40'h00_0000_4400);
`else
    chk("take_in", take_in, 8'h00);
    chk("take_flat", take_flat, 40'h0);
`endif
    cyc();
    start[2][2] = 1'b0;
    @(negedge clk);

    // Reset held two cycles while exec is BUSY abandons it without a stamp
    init_slots();
    start[3][2] = 1'b1;
    @(negedge clk);
    cyc();
    set_ready(2);
    @(negedge clk);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    cyc();
    @(negedge clk);
    cyc();
    rst = 1'b0;
    start[3][2] = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", unit_busy, 3'b000);
    chk("mid_rst_valid", {bus.ex_valid, bus.mem_valid, bus.wb_valid}, 3'b000);
    chk("mid_rst_err", dispatch_err, 1'b0);
    chk("mid_rst_stamp_flat", stamp_flat, 24'h0);
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("mid_rst_no_stamp%0d", n), stamp_in, 8'h00);
      cyc();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
